// File: rtl/tetris_action_arbiter_if.sv
// Handshake bundle between the action arbiter and the game-state move/collision datapath.
// master = arbiter side, slave = datapath side.
interface tetris_action_arbiter_if;
    logic       act_valid;
    logic [1:0] act_code;
    logic       act_ready;
    logic       chk_done;
    logic       chk_collide;
    logic       move_accept;
    logic       move_reject;
    logic       lock_req;
    logic       lock_ack;

    modport master (
        output act_valid,
        output act_code,
        output move_accept,
        output move_reject,
        output lock_req,
        input  act_ready,
        input  chk_done,
        input  chk_collide,
        input  lock_ack
    );

    modport slave (
        input  act_valid,
        input  act_code,
        input  move_accept,
        input  move_reject,
        input  lock_req,
        output act_ready,
        output chk_done,
        output chk_collide,
        output lock_ack
    );
endinterface

// File: rtl/tetris_action_arbiter.sv
// Serialises down/left/right/rotate requests into the move/collision datapath, one at a time.
// Optional LOCK_GRACE_EN: first down-collision is rejected, and only a second one locks the piece.
module tetris_action_arbiter #(
    parameter int CHK_TIMEOUT = 255
) (
    input  logic                           CLOCK_50,
    input  logic                           resetn,
    input  logic                           enable,
    input  logic                           left_final,
    input  logic                           right_final,
    input  logic                           rot_final,
    input  logic                           tick_gravity,
    tetris_action_arbiter_if.master        dp,
    output logic                           busy,
    output logic                           timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_LOCK = 2'd3
    } state_t;

    localparam logic [1:0]  CODE_DOWN  = 2'd0;
    localparam logic [1:0]  CODE_LEFT  = 2'd1;
    localparam logic [1:0]  CODE_RIGHT = 2'd2;
    localparam logic [1:0]  CODE_ROT   = 2'd3;
    localparam logic [16:0] TMO_LIMIT  = 17'(CHK_TIMEOUT);

    state_t      state_reg, state_next;

    // Source vectors are indexed by action code: 0 down, 1 left, 2 right, 3 rotate.
    logic [3:0]  pulse_vec;
    logic [3:0]  pend_reg, pend_next;
    logic [3:0]  cancel_mask;
    logic [3:0]  eligible;
    logic [3:0]  grant_vec;
    logic        cancel_lr;
    logic        grant_any;
    logic [1:0]  grant_code;

    logic [15:0] cnt_reg, cnt_next;
    logic        tmo_hit;

    logic        accept_evt, reject_evt, tmo_evt;

    logic        act_valid_reg,   act_valid_next;
    logic [1:0]  act_code_reg,    act_code_next;
    logic        move_accept_reg, move_accept_next;
    logic        move_reject_reg, move_reject_next;
    logic        lock_req_reg,    lock_req_next;
    logic        busy_reg,        busy_next;
    logic        timeout_err_reg, timeout_err_next;

`ifdef LOCK_GRACE_EN
    logic        grace_reg, grace_next;
`endif

    assign pulse_vec   = {rot_final, right_final, left_final, tick_gravity};
    assign cancel_lr   = pend_reg[CODE_LEFT] & pend_reg[CODE_RIGHT];
    assign cancel_mask = {1'b0, cancel_lr, cancel_lr, 1'b0};
    assign eligible    = pend_reg & ~cancel_mask;

    always_comb begin
        grant_code = CODE_DOWN;
        grant_vec  = 4'b0000;
        if (eligible[CODE_DOWN]) begin
            grant_code = CODE_DOWN;
        end else if (eligible[CODE_ROT]) begin
            grant_code = CODE_ROT;
        end else if (eligible[CODE_LEFT]) begin
            grant_code = CODE_LEFT;
        end else if (eligible[CODE_RIGHT]) begin
            grant_code = CODE_RIGHT;
        end
        grant_any = enable && (state_reg == S_IDLE) && (|eligible);
        if (grant_any) begin
            grant_vec[grant_code] = 1'b1;
        end
    end

    // Pulses arriving while disabled or during a lock are dropped, not deferred.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pend
            assign pend_next[gi] = (!enable || (state_reg == S_LOCK)) ? 1'b0 :
                                   ((pend_reg[gi] & ~grant_vec[gi] & ~cancel_mask[gi]) | pulse_vec[gi]);
        end
    endgenerate

    assign tmo_hit = ((state_reg == S_REQ) || (state_reg == S_WAIT)) &&
                     (({1'b0, cnt_reg} + 17'd1) >= TMO_LIMIT);

    always_comb begin
        cnt_next = cnt_reg;
        if (grant_any) begin
            cnt_next = 16'd0;
        end else if (((state_reg == S_REQ) || (state_reg == S_WAIT)) && (cnt_reg != 16'hFFFF)) begin
            cnt_next = cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_reg <= S_IDLE;
            pend_reg  <= 4'b0000;
            cnt_reg   <= 16'd0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            cnt_reg   <= cnt_next;
        end
    end

    // A verdict in the final budget cycle still counts; the timeout only fires without one.
    always_comb begin
        state_next = state_reg;
        accept_evt = 1'b0;
        reject_evt = 1'b0;
        tmo_evt    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (grant_any) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (tmo_hit) begin
                    tmo_evt    = 1'b1;
                    reject_evt = 1'b1;
                    state_next = S_IDLE;
                end else if (dp.act_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dp.chk_done) begin
                    if (!dp.chk_collide) begin
                        accept_evt = 1'b1;
                        state_next = S_IDLE;
                    end else if (act_code_reg != CODE_DOWN) begin
                        reject_evt = 1'b1;
                        state_next = S_IDLE;
                    end else begin
`ifdef LOCK_GRACE_EN
                        if (grace_reg) begin
                            state_next = S_LOCK;
                        end else begin
                            reject_evt = 1'b1;
                            state_next = S_IDLE;
                        end
`else
                        state_next = S_LOCK;
`endif
                    end
                end else if (tmo_hit) begin
                    tmo_evt    = 1'b1;
                    reject_evt = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_LOCK: begin
                if (dp.lock_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (!enable) begin
            state_next = S_IDLE;
            accept_evt = 1'b0;
            reject_evt = 1'b0;
            tmo_evt    = 1'b0;
        end
    end

`ifdef LOCK_GRACE_EN
    always_comb begin
        grace_next = grace_reg;
        if (enable && (state_reg == S_WAIT) && dp.chk_done && (act_code_reg == CODE_DOWN)) begin
            grace_next = dp.chk_collide;
        end
        if ((state_reg == S_LOCK) && (state_next == S_IDLE)) begin
            grace_next = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            grace_reg <= 1'b0;
        end else begin
            grace_reg <= grace_next;
        end
    end
`endif

    always_comb begin
        act_valid_next   = (state_next == S_REQ);
        lock_req_next    = (state_next == S_LOCK);
        busy_next        = (state_next != S_IDLE);
        move_accept_next = accept_evt;
        move_reject_next = reject_evt;
        timeout_err_next = timeout_err_reg | tmo_evt;
        act_code_next    = grant_any ? grant_code : act_code_reg;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            act_valid_reg   <= 1'b0;
            act_code_reg    <= 2'd0;
            move_accept_reg <= 1'b0;
            move_reject_reg <= 1'b0;
            lock_req_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            act_valid_reg   <= act_valid_next;
            act_code_reg    <= act_code_next;
            move_accept_reg <= move_accept_next;
            move_reject_reg <= move_reject_next;
            lock_req_reg    <= lock_req_next;
            busy_reg        <= busy_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    // Request and lock levels are withdrawn the moment play stops, ahead of the state change.
    assign dp.act_valid   = act_valid_reg & enable;
    assign dp.lock_req    = lock_req_reg & enable;
    assign dp.act_code    = act_code_reg;
    assign dp.move_accept = move_accept_reg;
    assign dp.move_reject = move_reject_reg;
    assign busy           = busy_reg;
    assign timeout_err    = timeout_err_reg;

endmodule

// File: tb/tb_tetris_action_arbiter.sv
// Bench for tetris_action_arbiter: vector table of single/double actions plus hand-written
// lock, timeout and enable-abort sequences; results are checked through an expectation queue.
module tb_tetris_action_arbiter;

    localparam int         TMO      = 8;
    localparam logic [1:0] RES_ACC  = 2'd1;
    localparam logic [1:0] RES_REJ  = 2'd2;
    localparam logic [1:0] RES_LOCK = 2'd3;

    typedef struct packed {
        logic [1:0] code;
        logic [1:0] res;
    } exp_t;

    typedef struct {
        logic [3:0] pulses;   // {rot, right, left, gravity}
        logic       collide;
        int         n_act;
        logic [1:0] code_a;
        logic [1:0] code_b;
    } vec_t;

    logic clk          = 1'b0;
    logic resetn       = 1'b0;
    logic enable       = 1'b1;
    logic left_final   = 1'b0;
    logic right_final  = 1'b0;
    logic rot_final    = 1'b0;
    logic tick_gravity = 1'b0;
    logic busy;
    logic timeout_err;

    tetris_action_arbiter_if dp();

    tetris_action_arbiter #(.CHK_TIMEOUT(TMO)) dut (
        .CLOCK_50     (clk),
        .resetn       (resetn),
        .enable       (enable),
        .left_final   (left_final),
        .right_final  (right_final),
        .rot_final    (rot_final),
        .tick_gravity (tick_gravity),
        .dp           (dp),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    logic lock_prev = 1'b0;
    logic [1:0] mon_kind;
    exp_t mon_e;
    vec_t vecs[11];

    // Scoreboard side: every accept/reject pulse and every lock_req rise pops one expectation.
    assign mon_kind = dp.move_accept ? RES_ACC :
                      dp.move_reject ? RES_REJ :
                      (dp.lock_req && !lock_prev) ? RES_LOCK : 2'd0;

    always @(negedge clk) begin
        lock_prev <= dp.lock_req;
        if (mon_kind != 2'd0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL result_unexpected: got code=%0d kind=%0d, required no result", dp.act_code, mon_kind);
            end else begin
                mon_e = exp_q.pop_front();
                if ({dp.act_code, mon_kind} !== mon_e) begin
                    n_fail++;
                    $display("FAIL result: got code=%0d kind=%0d, required code=%0d kind=%0d",
                             dp.act_code, mon_kind, mon_e.code, mon_e.res);
                end else begin
                    $display("result ok: code=%0d kind=%0d", dp.act_code, mon_kind);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_pulses(input logic [3:0] p);
        tick_gravity = p[0];
        left_final   = p[1];
        right_final  = p[2];
        rot_final    = p[3];
        tick();
        {rot_final, right_final, left_final, tick_gravity} = 4'b0000;
    endtask

    // mode 1: first action after an idle pulse (checks the k+1 latency);
    // mode 2: back-to-back follower, must appear one cycle after the previous verdict.
    task automatic handshake(input logic [1:0] code, input logic collide, input int mode,
                             input int ready_dly, input int gap);
        if (mode == 1) begin
            chk("valid_before_grant", dp.act_valid, 0);
        end
        tick();
        chk("valid_after_grant", dp.act_valid, 1);
        chk("act_code", dp.act_code, code);
        for (int i = 0; i < ready_dly; i++) begin
            tick();
            chk("valid_held", {dp.act_valid, dp.act_code}, {1'b1, code});
        end
        dp.act_ready = 1'b1;
        tick();
        dp.act_ready = 1'b0;
        chk("valid_after_xfer", {dp.act_valid, busy}, 2'b01);
        for (int i = 0; i < gap; i++) tick();
        dp.chk_done    = 1'b1;
        dp.chk_collide = collide;
        tick();
        dp.chk_done    = 1'b0;
        dp.chk_collide = 1'b0;
    endtask

    task automatic idle_check(input int n);
        int activity;
        activity = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (dp.act_valid || dp.move_accept || dp.move_reject || dp.lock_req || busy) activity++;
        end
        chk("idle_no_activity", activity, 0);
    endtask

    initial begin
        int lock_cnt;
        int t_seen;

        dp.act_ready = 1'b0; dp.chk_done = 1'b0; dp.chk_collide = 1'b0; dp.lock_ack = 1'b0;

        vecs[0]  = '{4'b0010, 1'b0, 1, 2'd1, 2'd0};
        vecs[1]  = '{4'b0100, 1'b0, 1, 2'd2, 2'd0};
        vecs[2]  = '{4'b1000, 1'b1, 1, 2'd3, 2'd0};
        vecs[3]  = '{4'b1110, 1'b0, 1, 2'd3, 2'd0};
        vecs[4]  = '{4'b0110, 1'b0, 0, 2'd0, 2'd0};
        vecs[5]  = '{4'b0001, 1'b0, 1, 2'd0, 2'd0};
        vecs[6]  = '{4'b1001, 1'b0, 2, 2'd0, 2'd3};
        vecs[7]  = '{4'b1100, 1'b1, 2, 2'd3, 2'd2};
        vecs[8]  = '{4'b0111, 1'b0, 1, 2'd0, 2'd0};
        vecs[9]  = '{4'b1010, 1'b0, 2, 2'd3, 2'd1};
        vecs[10] = '{4'b0010, 1'b1, 1, 2'd1, 2'd0};

        // Reset
        repeat (9) tick();
        chk("reset_hold", {dp.act_valid, dp.act_code, dp.move_accept, dp.move_reject, dp.lock_req, busy, timeout_err}, 0);
        tick();
        resetn = 1'b1;
        tick();
        chk("reset_outputs", {dp.act_valid, dp.act_code, dp.move_accept, dp.move_reject, dp.lock_req, timeout_err}, 0);
        chk("reset_busy", busy, 0);
        $display("reset done");

        // Single left with slow ready and a delayed verdict
        exp_q.push_back({2'd1, RES_ACC});
        drive_pulses(4'b0010);
        handshake(2'd1, 1'b0, 1, 2, 1);
        idle_check(4);
        $display("single left done");

        for (int v = 0; v < 11; v++) begin
            if (vecs[v].n_act >= 1) exp_q.push_back({vecs[v].code_a, vecs[v].collide ? RES_REJ : RES_ACC});
            if (vecs[v].n_act >= 2) exp_q.push_back({vecs[v].code_b, vecs[v].collide ? RES_REJ : RES_ACC});
            drive_pulses(vecs[v].pulses);
            if (vecs[v].n_act >= 1) handshake(vecs[v].code_a, vecs[v].collide, 1, 0, 0);
            if (vecs[v].n_act >= 2) handshake(vecs[v].code_b, vecs[v].collide, 2, 0, 0);
            idle_check(4);
            $display("vector %0d: pulses=%b actions=%0d", v, vecs[v].pulses, vecs[v].n_act);
        end

        // Gravity collision and lock
`ifdef LOCK_GRACE_EN
        exp_q.push_back({2'd0, RES_REJ});
        drive_pulses(4'b0001);
        handshake(2'd0, 1'b1, 1, 0, 0);
        idle_check(2);
`endif
        exp_q.push_back({2'd0, RES_LOCK});
        drive_pulses(4'b0001);
        handshake(2'd0, 1'b1, 1, 0, 0);
        lock_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (dp.lock_req) lock_cnt++;
            left_final  = (i == 1);
            dp.lock_ack = (i == 4);
            tick();
        end
        left_final  = 1'b0;
        dp.lock_ack = 1'b0;
        chk("lock_len", lock_cnt, 5);
        chk("lock_released", dp.lock_req, 0);
        idle_check(6);
        $display("gravity lock done: lock cycles=%0d", lock_cnt);

        // Timeout
        chk("timeout_err_clear", timeout_err, 0);
        exp_q.push_back({2'd2, RES_REJ});
        drive_pulses(4'b0100);
        tick();
        chk("tmo_valid", dp.act_valid, 1);
        dp.act_ready = 1'b1;
        tick();
        dp.act_ready = 1'b0;
        t_seen = -1;
        for (int i = 0; i < 20; i++) begin
            if (dp.move_reject) begin
                t_seen = i;
                break;
            end
            tick();
        end
        chk("timeout_latency", t_seen, TMO - 1);
        chk("timeout_err_set", timeout_err, 1);
        tick();
        chk("timeout_idle", busy, 0);
        exp_q.push_back({2'd1, RES_ACC});
        drive_pulses(4'b0010);
        handshake(2'd1, 1'b0, 1, 0, 0);
        idle_check(3);
        chk("timeout_err_sticky", timeout_err, 1);
        $display("timeout done: latency=%0d", t_seen);

        // Enable dropped in S_WAIT, then a stale verdict
        drive_pulses(4'b1000);
        tick();
        chk("abort_wait_valid", dp.act_valid, 1);
        dp.act_ready = 1'b1;
        tick();
        dp.act_ready = 1'b0;
        enable = 1'b0;
        tick();
        chk("abort_wait_state", {dp.act_valid, busy}, 0);
        enable = 1'b1;
        dp.chk_done = 1'b1;
        tick();
        dp.chk_done = 1'b0;
        idle_check(4);
        $display("abort in wait done");

        // Enable dropped in S_REQ
        drive_pulses(4'b0010);
        tick();
        chk("abort_req_valid", dp.act_valid, 1);
        enable = 1'b0;
        #1;
        chk("abort_req_drop", dp.act_valid, 0);
        tick();
        enable = 1'b1;
        chk("abort_req_busy", busy, 0);
        idle_check(4);
        $display("abort in req done");

        tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
